// File: rtl/mips_bus_pkg.sv
// Shared types, encodings and the alignment rule for the MIPS load/store bus master.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } bus_state_t;

    typedef logic [1:0] mem_size_t;
    typedef logic [1:0] bus_err_t;

    localparam mem_size_t SIZE_BYTE  = 2'b00;
    localparam mem_size_t SIZE_HALF  = 2'b01;
    localparam mem_size_t SIZE_WORD  = 2'b10;
    localparam mem_size_t SIZE_DWORD = 2'b11;

    localparam bus_err_t ERR_OK       = 2'b00;
    localparam bus_err_t ERR_MISALIGN = 2'b01;
    localparam bus_err_t ERR_TIMEOUT  = 2'b10;

    // Doublewords are only legal when the bus is wide enough to carry them in one beat.
    function automatic logic is_misaligned(input mem_size_t size, input logic [2:0] addr_lo,
                                           input logic dword_ok);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = |addr_lo[1:0];
            default:   bad = !dword_ok || (|addr_lo);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mips_lane_align.sv
// Combinational byte-lane steering: byteenable and store data placement, load data
// extraction with sign/zero extension.
module mips_lane_align
    import mips_bus_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                   size,
    input  logic [$clog2(DATA_W/8)-1:0]  lane,
    input  logic                         is_signed,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W-1:0]            rdata,
    output logic [DATA_W/8-1:0]          byteenable,
    output logic [DATA_W-1:0]            wdata_lane,
    output logic [DATA_W-1:0]            rdata_ext
);
    localparam int BE_W = DATA_W / 8;

    logic [BE_W-1:0]   be_base;
    logic [DATA_W-1:0] shifted;
    logic              sign_bit;

    always_comb begin
        for (int i = 0; i < BE_W; i++) begin
            be_base[i] = (i < (1 << size));
        end
        byteenable = be_base << lane;
    end

    assign wdata_lane = wdata << {lane, 3'b000};

    // Bring the addressed lane down to bit 0, then fill above the access width.
    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: sign_bit = shifted[7];
            SIZE_HALF: sign_bit = shifted[15];
            SIZE_WORD: sign_bit = shifted[31];
            default:   sign_bit = shifted[DATA_W-1];
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            rdata_ext[i] = (i < (8 << size)) ? shifted[i] : (is_signed & sign_bit);
        end
    end

endmodule

// File: rtl/mips_bus_master_unit.sv
// Load/store bus master between the multi-cycle MIPS datapath and Avalon-MM:
// one request at a time, held across waitrequest, with misalignment and timeout errors.
module mips_bus_master_unit
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_error,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    input  logic                waitrequest,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   readdata
);
    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK   = ~ADDR_W'(BE_W - 1);

    bus_state_t        state, next_state;
    mem_size_t         size_q;
    logic              signed_q;
    logic [LANE_W-1:0] lane_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              accept, misaligned, xfer_done, xfer_timeout;

    mem_size_t         align_size;
    logic [LANE_W-1:0] align_lane;
    logic              align_signed;
    logic [BE_W-1:0]   be_lane;
    logic [DATA_W-1:0] wdata_lane, rdata_ext;

    assign req_ready  = (state == IDLE);
    assign misaligned = is_misaligned(req_size, req_addr[2:0], DATA_W == 64);

    // One aligner serves both phases: live request fields while IDLE, latched ones afterwards.
    assign align_size   = req_ready ? req_size : size_q;
    assign align_lane   = req_ready ? req_addr[LANE_W-1:0] : lane_q;
    assign align_signed = req_ready ? req_signed : signed_q;

    mips_lane_align #(.DATA_W(DATA_W)) u_align (
        .size       (align_size),
        .lane       (align_lane),
        .is_signed  (align_signed),
        .wdata      (req_wdata),
        .rdata      (readdata),
        .byteenable (be_lane),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Completion wins over timeout when waitrequest drops on the last allowed cycle.
    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        xfer_done    = 1'b0;
        xfer_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = misaligned ? RESP : BUS;
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    xfer_done  = 1'b1;
                    next_state = RESP;
                end else if ((TIMEOUT != 0) && (wait_cnt == TIMEOUT_LAST)) begin
                    xfer_timeout = 1'b1;
                    next_state   = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            size_q     <= SIZE_BYTE;
            signed_q   <= 1'b0;
            lane_q     <= '0;
            wait_cnt   <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_error  <= ERR_OK;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= '0;
            writedata  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                size_q   <= req_size;
                signed_q <= req_signed;
                lane_q   <= req_addr[LANE_W-1:0];
                wait_cnt <= '0;
                if (misaligned) begin
                    rsp_valid <= 1'b1;
                    rsp_error <= ERR_MISALIGN;
                    rsp_rdata <= '0;
                end else begin
                    read       <= !req_write;
                    write      <= req_write;
                    address    <= req_addr & ALIGN_MASK;
                    byteenable <= be_lane;
                    writedata  <= req_write ? wdata_lane : '0;
                end
            end
            if (xfer_done || xfer_timeout) begin
                read       <= 1'b0;
                write      <= 1'b0;
                address    <= '0;
                byteenable <= '0;
                writedata  <= '0;
                rsp_valid  <= 1'b1;
                rsp_error  <= xfer_done ? ERR_OK : ERR_TIMEOUT;
                rsp_rdata  <= (xfer_done && read) ? rdata_ext : '0;
            end else if ((state == BUS) && waitrequest) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_bus_master_unit.sv
// Scoreboard bench for mips_bus_master_unit: a 32-bit unit with a short timeout and a
// 64-bit unit without timeout, each driven with directed and random requests.
module tb_mips_bus_master_unit;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] ad;
        logic [63:0] wd;
        int          waits;
        logic [63:0] rd;
    } req_t;

    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  err;
        int          acc;
        int          delta;
    } exp_rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  be;
        logic [63:0] wdata;
        int          waits;
        logic [63:0] rdata;
    } exp_bus_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit done_flag [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules written as plain byte arithmetic.
    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic bit model_misaligned(input int w, input logic [1:0] sz, input logic [31:0] ad);
        int nbytes = 1 << sz;
        if (nbytes > w / 8) return 1'b1;
        return (ad % nbytes) != 0;
    endfunction

    function automatic logic [7:0] model_be(input int w, input logic [1:0] sz, input logic [31:0] ad);
        int lane   = int'(ad % (w / 8));
        int nbytes = 1 << sz;
        return 8'(((1 << nbytes) - 1) << lane);
    endfunction

    function automatic logic [63:0] model_wdata(input int w, input logic [31:0] ad, input logic [63:0] wd);
        int lane = int'(ad % (w / 8));
        return (wd << (8 * lane)) & wmask(w);
    endfunction

    function automatic logic [63:0] model_load(input int w, input logic [1:0] sz, input logic sg,
                                               input logic [31:0] ad, input logic [63:0] rd);
        int          lane  = int'(ad % (w / 8));
        int          nbits = 8 << sz;
        logic [63:0] val, mask;
        val  = (rd & wmask(w)) >> (8 * lane);
        mask = (nbits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
        val  = val & mask;
        if (sg && val[nbits-1]) val = val | ~mask;
        return val & wmask(w);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_unit
        localparam int W  = (g == 0) ? 32 : 64;
        localparam int BW = W / 8;
        localparam int TO = (g == 0) ? 4 : 0;

        logic          reset = 1'b1;
        logic          req_valid = 1'b0;
        logic          req_ready;
        logic          req_write = 1'b0;
        logic [1:0]    req_size = 2'b00;
        logic          req_signed = 1'b0;
        logic [31:0]   req_addr = '0;
        logic [W-1:0]  req_wdata = '0;
        logic          rsp_valid;
        logic [W-1:0]  rsp_rdata;
        logic [1:0]    rsp_error;
        logic [31:0]   address;
        logic          read, write;
        logic          waitrequest = 1'b0;
        logic [W-1:0]  writedata;
        logic [BW-1:0] byteenable;
        logic [W-1:0]  readdata = '0;

        int cyc = 0;
        always @(posedge clk) cyc <= cyc + 1;

        exp_rsp_t rsp_q[$];
        exp_bus_t bus_q[$];

        mips_bus_master_unit #(.ADDR_W(32), .DATA_W(W), .TIMEOUT(TO)) dut (
            .clk         (clk),
            .reset       (reset),
            .req_valid   (req_valid),
            .req_ready   (req_ready),
            .req_write   (req_write),
            .req_size    (req_size),
            .req_signed  (req_signed),
            .req_addr    (req_addr),
            .req_wdata   (req_wdata),
            .rsp_valid   (rsp_valid),
            .rsp_rdata   (rsp_rdata),
            .rsp_error   (rsp_error),
            .address     (address),
            .read        (read),
            .write       (write),
            .waitrequest (waitrequest),
            .writedata   (writedata),
            .byteenable  (byteenable),
            .readdata    (readdata)
        );

        // Present a request, push the expected bus beat and response at the accepting edge.
        task automatic applyStimulus(input req_t r, input bit expect_rsp);
            int       budget = 0;
            bit       mis, timed;
            exp_rsp_t er;
            exp_bus_t eb;
            @(negedge clk);
            req_valid  = 1'b1;
            req_write  = r.wr;
            req_size   = r.sz;
            req_signed = r.sg;
            req_addr   = r.ad;
            req_wdata  = r.wd[W-1:0];
            while (!req_ready && budget < 64) begin
                @(negedge clk);
                budget++;
            end
            if (!req_ready) begin
                check("req_ready_bound", req_ready, 1'b1);
                req_valid = 1'b0;
                return;
            end
            mis   = model_misaligned(W, r.sz, r.ad);
            timed = (TO != 0) && (r.waits >= TO);
            if (!mis) begin
                eb.addr  = r.ad & ~(BW - 1);
                eb.wr    = r.wr;
                eb.be    = model_be(W, r.sz, r.ad);
                eb.wdata = model_wdata(W, r.ad, r.wd);
                eb.waits = r.waits;
                eb.rdata = r.rd & wmask(W);
                bus_q.push_back(eb);
            end
            if (expect_rsp) begin
                er.acc   = cyc + 1;
                er.err   = mis ? 2'b01 : (timed ? 2'b10 : 2'b00);
                er.delta = mis ? 0 : (timed ? TO : 1 + r.waits);
                er.rdata = (mis || timed || r.wr) ? 64'h0 : model_load(W, r.sz, r.sg, r.ad, r.rd);
                rsp_q.push_back(er);
            end
            @(posedge clk);
            #1;
            req_valid  = 1'b0;
            req_write  = 1'($urandom);
            req_size   = 2'($urandom);
            req_signed = 1'($urandom);
            req_addr   = $urandom;
            req_wdata  = W'({$urandom, $urandom});
        endtask

        // Avalon slave: checks each strobed beat and stalls it for the planned wait count.
        exp_bus_t cur;
        bit       active = 1'b0;
        int       wcnt = 0;
        always @(negedge clk) begin
            if (reset) begin
                active      = 1'b0;
                waitrequest = 1'b0;
            end else if (read || write) begin
                if (!active) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_strobe", {62'b0, read, write}, 64'h0);
                        waitrequest = 1'b0;
                    end else begin
                        cur    = bus_q.pop_front();
                        active = 1'b1;
                        wcnt   = 0;
                    end
                end
                if (active) begin
                    check("address", address, cur.addr);
                    check("read", read, !cur.wr);
                    check("write", write, cur.wr);
                    check("byteenable", byteenable, cur.be);
                    if (cur.wr) check("writedata", writedata, cur.wdata);
                    if (wcnt < cur.waits) begin
                        waitrequest = 1'b1;
                        readdata    = W'({$urandom, $urandom});
                        wcnt++;
                    end else begin
                        waitrequest = 1'b0;
                        readdata    = cur.rdata[W-1:0];
                        active      = 1'b0;
                    end
                end
            end else begin
                active      = 1'b0;
                waitrequest = 1'b0;
                readdata    = W'({$urandom, $urandom});
            end
        end

        // Response monitor: every rsp_valid pulse must match the oldest outstanding expectation.
        exp_rsp_t e;
        always @(negedge clk) begin
            if (!reset && rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", rsp_valid, 1'b0);
                end else begin
                    e = rsp_q.pop_front();
                    checkOutput(e);
                end
            end
            if (read && write) check("strobe_exclusive", {read, write}, 2'b00);
        end

        task automatic checkOutput(input exp_rsp_t x);
            check("rsp_rdata", rsp_rdata, x.rdata);
            check("rsp_error", rsp_error, x.err);
            check("rsp_latency", cyc - x.acc, x.delta);
        endtask

        initial begin
            req_t r;
            req_t dir[$];
            repeat (3) @(negedge clk);
            check("rst_req_ready", req_ready, 1'b1);
            check("rst_rsp_valid", rsp_valid, 1'b0);
            check("rst_rsp_rdata", rsp_rdata, 64'h0);
            check("rst_rsp_error", rsp_error, 2'b00);
            check("rst_strobes", {read, write}, 2'b00);
            check("rst_address", address, 32'h0);
            check("rst_byteenable", byteenable, 8'h0);
            check("rst_writedata", writedata, 64'h0);
            reset = 1'b0;

            if (W == 32) begin
                dir.push_back('{1'b0, 2'd0, 1'b1, 32'h1003, 64'h0, 0, 64'h80FF_FFFF});
                dir.push_back('{1'b1, 2'd1, 1'b0, 32'h2002, 64'hBEEF, 3, 64'h0});
                dir.push_back('{1'b0, 2'd2, 1'b0, 32'h3001, 64'h0, 0, 64'h1234_5678});
                dir.push_back('{1'b0, 2'd2, 1'b0, 32'h4000, 64'h0, 20, 64'hCAFE_F00D});
                dir.push_back('{1'b0, 2'd2, 1'b1, 32'h4004, 64'h0, 1, 64'h0BAD_BEEF});
                dir.push_back('{1'b0, 2'd3, 1'b0, 32'h4008, 64'h0, 0, 64'h0});
            end else begin
                dir.push_back('{1'b0, 2'd3, 1'b1, 32'h0008, 64'h0, 0, 64'h0123_4567_89AB_CDEF});
                dir.push_back('{1'b0, 2'd1, 1'b0, 32'h000E, 64'h0, 0, 64'h0123_4567_89AB_CDEF});
                dir.push_back('{1'b1, 2'd0, 1'b0, 32'h0105, 64'h5A, 2, 64'h0});
                dir.push_back('{1'b0, 2'd2, 1'b1, 32'h0204, 64'h0, 9, 64'h8000_0001_0000_0000});
                dir.push_back('{1'b1, 2'd3, 1'b0, 32'h0304, 64'h0, 0, 64'h0});
            end
            foreach (dir[i]) applyStimulus(dir[i], 1'b1);

            // Reset in the second bus cycle must abort silently.
            r = '{1'b0, 2'd2, 1'b0, 32'h5000, 64'h0, 10, 64'h0};
            applyStimulus(r, 1'b0);
            @(negedge clk);
            check("strobe_first_bus_cycle", read, 1'b1);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("abort_read", read, 1'b0);
            check("abort_rsp_valid", rsp_valid, 1'b0);
            check("abort_req_ready", req_ready, 1'b1);
            reset = 1'b0;

            for (int n = 0; n < 40; n++) begin
                r.wr = 1'($urandom);
                r.sz = 2'($urandom);
                r.sg = 1'($urandom);
                r.ad = $urandom;
                if ($urandom_range(0, 3) != 0) r.ad = r.ad & ~((32'd1 << r.sz) - 32'd1);
                r.wd    = {$urandom, $urandom};
                r.rd    = {$urandom, $urandom};
                r.waits = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3));
                applyStimulus(r, 1'b1);
            end

            repeat (30) @(negedge clk);
            check("rsp_queue_drained", rsp_q.size(), 64'h0);
            check("bus_queue_drained", bus_q.size(), 64'h0);
            done_flag[g] = 1'b1;
        end
    end

    initial begin
        fork
            wait (done_flag[0] && done_flag[1]);
            begin
                #500000;
                check("run_time_bound", {done_flag[1], done_flag[0]}, 2'b11);
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
